lbt_channel_sense: RTL and testbench

//  Listen-before-talk channel sensing stage. Sits directly upstream of the link

---
 rtl/lbt_pkg.sv | 19 +
 rtl/lbt_channel_sense_if.sv | 28 ++
 rtl/lbt_lfsr16.sv | 22 ++
 rtl/lbt_channel_sense.sv | 122 ++++++++++++
 tb/tb_lbt_channel_sense.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lbt_pkg.sv
// Shared types and LFSR constants for the listen-before-talk channel sensing stage.
package lbt_pkg;

  typedef enum logic [1:0] {
    LBT_IDLE,
    LBT_SENSE,
    LBT_BACKOFF,
    LBT_DONE
  } lbt_sense_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/lbt_channel_sense_if.sv
// Request/sample/verdict bundle between the link control FSM and the LBT sensing stage.
interface lbt_channel_sense_if #(
  parameter int unsigned EW           = 8,
  parameter int unsigned MAX_ATTEMPTS = 4
);
  localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1);

  logic          sense_req;
  logic          sense_abort;
  logic          smp_valid;
  logic [EW-1:0] smp_energy;
  logic [EW-1:0] thr;
  logic          lbt_busy;
  logic          lbt_done;
  logic          lbt_clear;
  logic [AW-1:0] lbt_attempts;

  modport master (
    output sense_req, sense_abort, smp_valid, smp_energy, thr,
    input  lbt_busy, lbt_done, lbt_clear, lbt_attempts
  );

  modport slave (
    input  sense_req, sense_abort, smp_valid, smp_energy, thr,
    output lbt_busy, lbt_done, lbt_clear, lbt_attempts
  );

endinterface

// File: rtl/lbt_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the backoff randomness source.
module lbt_lfsr16
  import lbt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/lbt_channel_sense.sv
// Listen-before-talk sensing: waits for a run of quiet energy samples, backs off randomly
// on a busy channel, and reports one clear/gave-up verdict per request.
module lbt_channel_sense
  import lbt_pkg::*;
#(
  parameter int unsigned EW           = 8,
  parameter int unsigned QUIET_LEN    = 16,
  parameter int unsigned MAX_ATTEMPTS = 4,
  parameter int unsigned BO_W         = 6,
  parameter int unsigned MIN_BO       = 8
) (
  input logic               clk,
  input logic               rst,
  lbt_channel_sense_if.slave bus
);

  localparam int unsigned AW  = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned QW  = $clog2(QUIET_LEN + 1);
  localparam int unsigned BCW = $clog2((2 ** BO_W) + MIN_BO);

  lbt_sense_state_t state_q;
  logic [QW-1:0]    quiet_cnt;
  logic [BCW-1:0]   bo_cnt;
  logic [AW-1:0]    attempts_q;
  logic             busy_q;
  logic             done_q;
  logic             clear_q;

  logic [15:0]      lfsr;
  logic             quiet_smp;
  logic [BCW-1:0]   bo_load;
  logic             unused_lfsr;

  lbt_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  // Equal-to-threshold energy counts as busy
  assign quiet_smp   = bus.smp_energy < bus.thr;
  assign bo_load     = BCW'(lfsr[BO_W-1:0]) + BCW'(MIN_BO);
  assign unused_lfsr = ^lfsr[15:BO_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LBT_IDLE;
      quiet_cnt  <= '0;
      bo_cnt     <= '0;
      attempts_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      unique case (state_q)
        LBT_IDLE: begin
          if (bus.sense_req && !bus.sense_abort) begin
            state_q    <= LBT_SENSE;
            quiet_cnt  <= '0;
            attempts_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        LBT_SENSE: begin
          if (bus.sense_abort) begin
            state_q <= LBT_IDLE;
            busy_q  <= 1'b0;
          end else if (bus.smp_valid) begin
            if (quiet_smp) begin
              if (quiet_cnt < QW'(QUIET_LEN)) begin
                quiet_cnt <= quiet_cnt + 1'b1;
              end
              if (quiet_cnt == QW'(QUIET_LEN - 1)) begin
                state_q <= LBT_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                clear_q <= 1'b1;
              end
            end else begin
              quiet_cnt  <= '0;
              attempts_q <= attempts_q + 1'b1;
              if (attempts_q == AW'(MAX_ATTEMPTS - 1)) begin
                state_q <= LBT_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= LBT_BACKOFF;
                bo_cnt  <= bo_load;
              end
            end
          end
        end
        LBT_BACKOFF: begin
          if (bus.sense_abort) begin
            state_q <= LBT_IDLE;
            busy_q  <= 1'b0;
          end else if (bo_cnt == BCW'(1)) begin
            state_q   <= LBT_SENSE;
            quiet_cnt <= '0;
          end else begin
            bo_cnt <= bo_cnt - 1'b1;
          end
        end
        LBT_DONE: begin
          state_q <= LBT_IDLE;
        end
        default: begin
          state_q <= LBT_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lbt_busy     = busy_q;
  assign bus.lbt_done     = done_q;
  assign bus.lbt_clear    = clear_q;
  assign bus.lbt_attempts = attempts_q;

endmodule

// File: tb/tb_lbt_channel_sense.sv
// Directed bench for lbt_channel_sense: clear, backoff, give-up, abort, ignored req, reset.
module tb_lbt_channel_sense;
  import lbt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  lbt_channel_sense_if #(.EW(8), .MAX_ATTEMPTS(4)) bus ();

  lbt_channel_sense #(
    .EW           (8),
    .QUIET_LEN    (16),
    .MAX_ATTEMPTS (4),
    .BO_W         (6),
    .MIN_BO       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference LFSR, right-shift Galois with taps 16,14,13,11
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  always @(negedge clk) if (bus.lbt_done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int  exp_bo;
    int  d0;
    bit  busy_ok;
    bit  got;

    rst = 1'b1;
    bus.sense_req = 1'b0;
    bus.sense_abort = 1'b0;
    bus.smp_valid = 1'b0;
    bus.smp_energy = 8'd0;
    bus.thr = 8'd10;
    step();
    step();
    chk("rst_busy", 32'(bus.lbt_busy), 32'd0);
    chk("rst_done", 32'(bus.lbt_done), 32'd0);
    chk("rst_clear", 32'(bus.lbt_clear), 32'd0);
    chk("rst_attempts", 32'(bus.lbt_attempts), 32'd0);
    chk("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);
    rst = 1'b0;
    step();
    chk("lfsr_run", 32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr));

    // 1: sixteen quiet samples
    bus.sense_req = 1'b1;
    step();
    bus.sense_req = 1'b0;
    chk("t1_busy_rise", 32'(bus.lbt_busy), 32'd1);
    bus.smp_valid = 1'b1;
    bus.smp_energy = 8'd3;
    busy_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i < 15 && (bus.lbt_busy !== 1'b1 || bus.lbt_done !== 1'b0)) busy_ok = 1'b0;
    end
    chk("t1_busy_throughout", 32'(busy_ok), 32'd1);
    chk("t1_done", 32'(bus.lbt_done), 32'd1);
    chk("t1_clear", 32'(bus.lbt_clear), 32'd1);
    chk("t1_attempts", 32'(bus.lbt_attempts), 32'd0);
    chk("t1_busy_low", 32'(bus.lbt_busy), 32'd0);
    bus.smp_valid = 1'b0;
    step();
    chk("t1_done_pulse", 32'(bus.lbt_done), 32'd0);

    // 2: energy equal to threshold is busy, random backoff, then clear
    bus.sense_req = 1'b1;
    step();
    bus.sense_req = 1'b0;
    bus.smp_valid = 1'b1;
    bus.smp_energy = 8'd3;
    repeat (5) step();
    chk("t2_quiet5", 32'(dut.quiet_cnt), 32'd5);
    bus.smp_energy = 8'd10;
    exp_bo = int'(m_lfsr[5:0]) + 8;
    step();
    chk("t2_state_bo", 32'(dut.state_q), 32'(LBT_BACKOFF));
    chk("t2_attempts", 32'(bus.lbt_attempts), 32'd1);
    chk("t2_bo_cnt", 32'(dut.bo_cnt), 32'(exp_bo));
    bus.smp_energy = 8'd200;
    repeat (exp_bo - 1) step();
    chk("t2_still_bo", 32'(dut.state_q), 32'(LBT_BACKOFF));
    chk("t2_busy_bo", 32'(bus.lbt_busy), 32'd1);
    bus.smp_energy = 8'd3;
    step();
    chk("t2_back_sense", 32'(dut.state_q), 32'(LBT_SENSE));
    chk("t2_quiet_restart", 32'(dut.quiet_cnt), 32'd0);
    repeat (15) step();
    chk("t2_no_done_15", 32'(bus.lbt_done), 32'd0);
    step();
    chk("t2_done", 32'(bus.lbt_done), 32'd1);
    chk("t2_clear", 32'(bus.lbt_clear), 32'd1);
    chk("t2_attempts_end", 32'(bus.lbt_attempts), 32'd1);
    bus.smp_valid = 1'b0;
    step();

    // 3: always busy, give up after four detections
    bus.sense_req = 1'b1;
    step();
    bus.sense_req = 1'b0;
    bus.smp_valid = 1'b1;
    bus.smp_energy = 8'd200;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      step();
      if (bus.lbt_done === 1'b1) got = 1'b1;
    end
    chk("t3_done_seen", 32'(got), 32'd1);
    chk("t3_clear", 32'(bus.lbt_clear), 32'd0);
    chk("t3_attempts", 32'(bus.lbt_attempts), 32'd4);
    bus.smp_valid = 1'b0;
    step();

    // 4: abort in backoff
    d0 = done_cnt;
    bus.sense_req = 1'b1;
    step();
    bus.sense_req = 1'b0;
    bus.smp_valid = 1'b1;
    bus.smp_energy = 8'd200;
    step();
    bus.smp_valid = 1'b0;
    chk("t4_in_bo", 32'(dut.state_q), 32'(LBT_BACKOFF));
    repeat (3) step();
    bus.sense_abort = 1'b1;
    step();
    bus.sense_abort = 1'b0;
    chk("t4_idle", 32'(dut.state_q), 32'(LBT_IDLE));
    chk("t4_busy", 32'(bus.lbt_busy), 32'd0);
    repeat (100) step();
    chk("t4_no_done", 32'(done_cnt), 32'(d0));
    chk("t4_attempts_held", 32'(bus.lbt_attempts), 32'd1);

    // 5: abort beats req in idle; req during sense ignored
    bus.sense_req = 1'b1;
    bus.sense_abort = 1'b1;
    step();
    bus.sense_req = 1'b0;
    bus.sense_abort = 1'b0;
    chk("t5_stay_idle", 32'(dut.state_q), 32'(LBT_IDLE));
    chk("t5_busy", 32'(bus.lbt_busy), 32'd0);
    chk("t5_attempts_held", 32'(bus.lbt_attempts), 32'd1);
    bus.sense_req = 1'b1;
    step();
    bus.sense_req = 1'b0;
    chk("t5_attempts_clr", 32'(bus.lbt_attempts), 32'd0);
    bus.smp_valid = 1'b1;
    bus.smp_energy = 8'd3;
    repeat (4) step();
    bus.smp_valid = 1'b0;
    bus.sense_req = 1'b1;
    step();
    bus.sense_req = 1'b0;
    chk("t5_req_ignored_q", 32'(dut.quiet_cnt), 32'd4);
    chk("t5_req_ignored_st", 32'(dut.state_q), 32'(LBT_SENSE));
    bus.sense_abort = 1'b1;
    step();
    bus.sense_abort = 1'b0;

    // 6: valid gaps hold quiet count; reset mid-sense
    bus.sense_req = 1'b1;
    step();
    bus.sense_req = 1'b0;
    bus.smp_valid = 1'b1;
    bus.smp_energy = 8'd200;
    step();
    bus.smp_valid = 1'b0;
    for (int i = 0; i < 200; i++) if (dut.state_q != LBT_SENSE) step();
    chk("t6_sense", 32'(dut.state_q), 32'(LBT_SENSE));
    chk("t6_attempts", 32'(bus.lbt_attempts), 32'd1);
    bus.smp_valid = 1'b1;
    bus.smp_energy = 8'd3;
    repeat (4) step();
    bus.smp_valid = 1'b0;
    repeat (3) step();
    chk("t6_gap_hold", 32'(dut.quiet_cnt), 32'd4);
    bus.smp_valid = 1'b1;
    repeat (5) step();
    bus.smp_valid = 1'b0;
    chk("t6_quiet9", 32'(dut.quiet_cnt), 32'd9);
    rst = 1'b1;
    step();
    chk("t6_rst_busy", 32'(bus.lbt_busy), 32'd0);
    chk("t6_rst_done", 32'(bus.lbt_done), 32'd0);
    chk("t6_rst_clear", 32'(bus.lbt_clear), 32'd0);
    chk("t6_rst_attempts", 32'(bus.lbt_attempts), 32'd0);
    chk("t6_rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);
    chk("t6_rst_state", 32'(dut.state_q), 32'(LBT_IDLE));
    chk("t6_rst_quiet", 32'(dut.quiet_cnt), 32'd0);
    rst = 1'b0;
    step();
    chk("t6_lfsr_after", 32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr));
    chk("t6_no_done", 32'(done_cnt), 32'(d0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
